// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two memory requesters, the arbiter and the BRAM port.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dmem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  p0_req;
  logic                  p0_we;
  logic [BE_WIDTH-1:0]   p0_be;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic                  p0_lock;
  logic                  p0_gnt;
  logic                  p0_rvalid;
  logic [DATA_WIDTH-1:0] p0_rdata;

  logic                  p1_req;
  logic                  p1_we;
  logic [BE_WIDTH-1:0]   p1_be;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic                  p1_lock;
  logic                  p1_gnt;
  logic                  p1_rvalid;
  logic [DATA_WIDTH-1:0] p1_rdata;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [BE_WIDTH-1:0]   mem_byte_w_en;
  logic                  mem_r_en;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  lock_timeout;

  modport slave (
    input  p0_req, p0_we, p0_be, p0_addr, p0_wdata, p0_lock,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_be, p1_addr, p1_wdata, p1_lock,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_addr, mem_wdata, mem_byte_w_en, mem_r_en, lock_timeout,
    input  mem_rdata
  );

  modport master (
    output p0_req, p0_we, p0_be, p0_addr, p0_wdata, p0_lock,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_be, p1_addr, p1_wdata, p1_lock,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_addr, mem_wdata, mem_byte_w_en, mem_r_en, lock_timeout,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port round-robin arbiter for the data-memory BRAM port, with timed locks
// and a read-owner pipeline. Define DMEM_ARB_STATS_EN to add conflict/timeout counters.
module dmem_port_arbiter #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1,
  parameter int LOCK_MAX    = 16
) (
  input  logic                 sysclk,
  input  logic                 rst,
  dmem_port_arbiter_if.slave   bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]          conflict_cnt,
  output logic [15:0]          timeout_cnt
`endif
);
  localparam int BE_W = DATA_WIDTH / 8;

  localparam logic [1:0] ARB   = 2'd0;
  localparam logic [1:0] LOCK0 = 2'd1;
  localparam logic [1:0] LOCK1 = 2'd2;

  localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX - 1);

  logic [1:0] state_q, state_d;
  logic       rr_last_q, rr_last_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic       timeout_q, timeout_d;

  logic [MEM_LATENCY-1:0] pv_q, pv_d;
  logic [MEM_LATENCY-1:0] po_q, po_d;

  logic                  gnt0, gnt1, accept, win, release_x;
  logic                  win_we, win_lock;
  logic [BE_W-1:0]       win_be;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      case (state_q)
        ARB: begin
          gnt0 = bus.p0_req && (!bus.p1_req || rr_last_q);
          gnt1 = bus.p1_req && (!bus.p0_req || !rr_last_q);
        end
        LOCK0:   gnt0 = bus.p0_req;
        LOCK1:   gnt1 = bus.p1_req;
        default: ;
      endcase
    end
  end

  assign accept    = gnt0 | gnt1;
  assign win       = gnt1;
  assign win_we    = win ? bus.p1_we    : bus.p0_we;
  assign win_lock  = win ? bus.p1_lock  : bus.p0_lock;
  assign win_be    = win ? bus.p1_be    : bus.p0_be;
  assign win_addr  = win ? bus.p1_addr  : bus.p0_addr;
  assign win_wdata = win ? bus.p1_wdata : bus.p0_wdata;

  assign bus.p0_gnt        = gnt0;
  assign bus.p1_gnt        = gnt1;
  assign bus.mem_addr      = accept ? win_addr : '0;
  assign bus.mem_wdata     = accept ? win_wdata : '0;
  assign bus.mem_byte_w_en = (accept && win_we) ? win_be : '0;
  assign bus.mem_r_en      = accept && !win_we;
  assign bus.lock_timeout  = timeout_q;

  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    lock_cnt_d = lock_cnt_q;
    timeout_d  = 1'b0;
    release_x  = 1'b0;
    if (accept) rr_last_d = win;
    case (state_q)
      ARB: begin
        if (accept && win_lock) begin
          state_d    = win ? LOCK1 : LOCK0;
          lock_cnt_d = '0;
        end
      end
      LOCK0, LOCK1: begin
        lock_cnt_d = lock_cnt_q + 8'd1;
        release_x  = accept && !win_lock;
        if (release_x) begin
          state_d = ARB;
        end else if (lock_cnt_q == LOCK_LAST) begin
          // Forced exit: hand the next tie to the port that was locked out.
          state_d   = ARB;
          timeout_d = 1'b1;
          rr_last_d = (state_q == LOCK1);
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    pv_d    = pv_q;
    po_d    = po_q;
    pv_d[0] = accept && !win_we;
    po_d[0] = win;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      po_d[i] = po_q[i-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q    <= ARB;
      rr_last_q  <= 1'b1;
      lock_cnt_q <= '0;
      timeout_q  <= 1'b0;
      pv_q       <= '0;
      po_q       <= '0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      lock_cnt_q <= lock_cnt_d;
      timeout_q  <= timeout_d;
      pv_q       <= pv_d;
      po_q       <= po_d;
    end
  end

  // Masking with rst keeps an in-flight read from surfacing during reset.
  assign bus.p0_rvalid = !rst && pv_q[MEM_LATENCY-1] && !po_q[MEM_LATENCY-1];
  assign bus.p1_rvalid = !rst && pv_q[MEM_LATENCY-1] &&  po_q[MEM_LATENCY-1];
  assign bus.p0_rdata  = bus.mem_rdata;
  assign bus.p1_rdata  = bus.mem_rdata;

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge sysclk) begin
    if (rst) begin
      conflict_cnt <= '0;
      timeout_cnt  <= '0;
    end else begin
      if (bus.p0_req && bus.p1_req && conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 16'd1;
      if (timeout_q && timeout_cnt != 16'hFFFF)
        timeout_cnt <= timeout_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench: three arbiter instances (default, LOCK_MAX=4, MEM_LATENCY=2)
// sharing clock and reset; instance A has a small behavioural BRAM attached.
module tb_dmem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus_a ();
  dmem_port_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus_b ();
  dmem_port_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus_c ();

  dmem_port_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .MEM_LATENCY(1), .LOCK_MAX(16))
    dut_a (.sysclk(clk), .rst(rst), .bus(bus_a));
  dmem_port_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .MEM_LATENCY(1), .LOCK_MAX(4))
    dut_b (.sysclk(clk), .rst(rst), .bus(bus_b));
  dmem_port_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .MEM_LATENCY(2), .LOCK_MAX(16))
    dut_c (.sysclk(clk), .rst(rst), .bus(bus_c));

  // Behavioural BRAM for instance A: latency 1, byte writes, word i preset to A50000xx.
  logic [31:0] mem_a [0:4095];
  logic [31:0] rd_a;
  initial for (int i = 0; i < 4096; i++) mem_a[i] = 32'hA500_0000 | i;
  always @(posedge clk) begin
    if (bus_a.mem_r_en) rd_a <= mem_a[bus_a.mem_addr];
    for (int b = 0; b < 4; b++)
      if (bus_a.mem_byte_w_en[b]) mem_a[bus_a.mem_addr][8*b +: 8] <= bus_a.mem_wdata[8*b +: 8];
  end
  assign bus_a.mem_rdata = rd_a;
  assign bus_b.mem_rdata = 32'h0;
  assign bus_c.mem_rdata = 32'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    bus_a.p0_req = 0; bus_a.p0_we = 0; bus_a.p0_be = 0; bus_a.p0_addr = 0; bus_a.p0_wdata = 0; bus_a.p0_lock = 0;
    bus_a.p1_req = 0; bus_a.p1_we = 0; bus_a.p1_be = 0; bus_a.p1_addr = 0; bus_a.p1_wdata = 0; bus_a.p1_lock = 0;
    bus_b.p0_req = 0; bus_b.p0_we = 0; bus_b.p0_be = 0; bus_b.p0_addr = 0; bus_b.p0_wdata = 0; bus_b.p0_lock = 0;
    bus_b.p1_req = 0; bus_b.p1_we = 0; bus_b.p1_be = 0; bus_b.p1_addr = 0; bus_b.p1_wdata = 0; bus_b.p1_lock = 0;
    bus_c.p0_req = 0; bus_c.p0_we = 0; bus_c.p0_be = 0; bus_c.p0_addr = 0; bus_c.p0_wdata = 0; bus_c.p0_lock = 0;
    bus_c.p1_req = 0; bus_c.p1_we = 0; bus_c.p1_be = 0; bus_c.p1_addr = 0; bus_c.p1_wdata = 0; bus_c.p1_lock = 0;
  endtask

  initial begin
    idle_all();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Reset in force with both ports of A requesting (p1 a full write).
    @(negedge clk);
    bus_a.p0_req = 1; bus_a.p1_req = 1; bus_a.p1_we = 1; bus_a.p1_be = 4'hF;
    #1;
    chk("rst_p0_gnt", bus_a.p0_gnt, 0);
    chk("rst_p1_gnt", bus_a.p1_gnt, 0);
    chk("rst_bwen",   bus_a.mem_byte_w_en, 0);
    chk("rst_ren",    bus_a.mem_r_en, 0);
    chk("rst_rvalid", {bus_a.p0_rvalid, bus_a.p1_rvalid}, 0);
    chk("rst_lto",    bus_a.lock_timeout, 0);

    // Single p0 read on A.
    @(negedge clk);
    rst = 1'b0; idle_all();
    bus_a.p0_req = 1; bus_a.p0_addr = 12'h010;
    #1;
    chk("t1_p0_gnt",  bus_a.p0_gnt, 1);
    chk("t1_p1_gnt",  bus_a.p1_gnt, 0);
    chk("t1_ren",     bus_a.mem_r_en, 1);
    chk("t1_addr",    bus_a.mem_addr, 12'h010);
    chk("t1_bwen",    bus_a.mem_byte_w_en, 0);
    @(negedge clk);
    idle_all();
    #1;
    chk("t1_p0_rvalid", bus_a.p0_rvalid, 1);
    chk("t1_p1_rvalid", bus_a.p1_rvalid, 0);
    chk("t1_p0_rdata",  bus_a.p0_rdata, 32'hA500_0010);
    chk("t1_no_acc_addr", bus_a.mem_addr, 0);

    // Round robin on B: both read four cycles -> p0,p1,p0,p1.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle_all();
      if (i < 4) begin
        bus_b.p0_req = 1; bus_b.p0_addr = 12'h001;
        bus_b.p1_req = 1; bus_b.p1_addr = 12'h002;
      end
      #1;
      if (i < 4) begin
        chk($sformatf("rr%0d_p0_gnt", i), bus_b.p0_gnt, (i % 2 == 0));
        chk($sformatf("rr%0d_p1_gnt", i), bus_b.p1_gnt, (i % 2 == 1));
        chk($sformatf("rr%0d_addr", i),  bus_b.mem_addr, (i % 2 == 0) ? 12'h001 : 12'h002);
      end
      chk($sformatf("rr%0d_p0_rvalid", i), bus_b.p0_rvalid, (i > 0) && (i % 2 == 1));
      chk($sformatf("rr%0d_p1_rvalid", i), bus_b.p1_rvalid, (i > 0) && (i % 2 == 0));
    end

    // Lock on A: p1 locked write then unlocking read, p0 requesting throughout.
    @(negedge clk);
    idle_all();
    bus_a.p0_req = 1; bus_a.p0_addr = 12'h030;
    bus_a.p1_req = 1; bus_a.p1_we = 1; bus_a.p1_be = 4'hF; bus_a.p1_addr = 12'h020;
    bus_a.p1_wdata = 32'hDEAD_BEEF; bus_a.p1_lock = 1;
    #1;
    chk("lk_w_p1_gnt", bus_a.p1_gnt, 1);
    chk("lk_w_p0_gnt", bus_a.p0_gnt, 0);
    chk("lk_w_bwen",   bus_a.mem_byte_w_en, 4'hF);
    chk("lk_w_wdata",  bus_a.mem_wdata, 32'hDEAD_BEEF);
    chk("lk_w_ren",    bus_a.mem_r_en, 0);
    @(negedge clk);
    bus_a.p1_we = 0; bus_a.p1_be = 0; bus_a.p1_lock = 0;
    #1;
    chk("lk_r_p1_gnt", bus_a.p1_gnt, 1);
    chk("lk_r_p0_gnt", bus_a.p0_gnt, 0);
    chk("lk_r_ren",    bus_a.mem_r_en, 1);
    @(negedge clk);
    bus_a.p1_req = 0;
    #1;
    chk("lk_after_p0_gnt", bus_a.p0_gnt, 1);
    chk("lk_p1_rvalid",    bus_a.p1_rvalid, 1);
    chk("lk_p1_rdata",     bus_a.p1_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    idle_all();
    #1;
    chk("lk_p0_rvalid", bus_a.p0_rvalid, 1);
    chk("lk_p0_rdata",  bus_a.p0_rdata, 32'hA500_0030);

    // Lock timeout on B (LOCK_MAX=4): p0 holds lock, p1 writes continuously.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      idle_all();
      bus_b.p0_req = 1; bus_b.p0_we = 1; bus_b.p0_be = 4'h1; bus_b.p0_lock = 1;
      bus_b.p1_req = 1; bus_b.p1_we = 1; bus_b.p1_be = 4'h2;
      #1;
      chk($sformatf("to%0d_p0_gnt", i), bus_b.p0_gnt, (i != 5));
      chk($sformatf("to%0d_p1_gnt", i), bus_b.p1_gnt, (i == 5));
      chk($sformatf("to%0d_lto", i),    bus_b.lock_timeout, (i == 5));
    end

    // MEM_LATENCY=2 on C: p0 read, then p1 read.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle_all();
      if (i == 0) begin bus_c.p0_req = 1; bus_c.p0_addr = 12'h005; end
      if (i == 1) begin bus_c.p1_req = 1; bus_c.p1_addr = 12'h006; end
      #1;
      if (i == 0) chk("lat_p0_gnt", bus_c.p0_gnt, 1);
      if (i == 1) chk("lat_p1_gnt", bus_c.p1_gnt, 1);
      chk($sformatf("lat%0d_p0_rvalid", i), bus_c.p0_rvalid, (i == 2));
      chk($sformatf("lat%0d_p1_rvalid", i), bus_c.p1_rvalid, (i == 3));
    end

    // Reset one cycle after a p0 read on A.
    @(negedge clk);
    idle_all();
    bus_a.p0_req = 1; bus_a.p0_addr = 12'h010;
    #1;
    chk("rr_p0_gnt_pre", bus_a.p0_gnt, 1);
    @(negedge clk);
    rst = 1'b1;
    bus_a.p0_req = 1; bus_a.p1_req = 1; bus_a.p1_we = 1; bus_a.p1_be = 4'hF;
    #1;
    chk("mid_rst_p0_rvalid", bus_a.p0_rvalid, 0);
    chk("mid_rst_gnt",       {bus_a.p0_gnt, bus_a.p1_gnt}, 0);
    chk("mid_rst_bwen",      bus_a.mem_byte_w_en, 0);
    @(negedge clk);
    rst = 1'b0; idle_all();
    #1;
    chk("post_rst_p0_rvalid", bus_a.p0_rvalid, 0);
    chk("post_rst_lto",       bus_a.lock_timeout, 0);
    @(negedge clk);
    bus_a.p0_req = 1; bus_a.p0_addr = 12'h011;
    bus_a.p1_req = 1; bus_a.p1_addr = 12'h012;
    #1;
    chk("post_rst_tie_p0", bus_a.p0_gnt, 1);
    chk("post_rst_tie_p1", bus_a.p1_gnt, 0);
    chk("post_rst_p0_rvalid2", bus_a.p0_rvalid, 0);
    @(negedge clk);
    idle_all();
    #1;
    chk("post_rst_rd_rvalid", bus_a.p0_rvalid, 1);
    chk("post_rst_rd_rdata",  bus_a.p0_rdata, 32'hA500_0011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory BRAM port between two requesters: port 0 (CPU load/store path) and port 1 (debug/loader master).
- Arbitrates between them with a round-robin pointer.
- Supports atomic multi-access locks with a timeout.
- Routes synchronous read data back to the issuing port after a fixed memory latency.
- Sits between the CPU datapath/loader and the bram instance.

Parameters:
ADDR_WIDTH, 12, word address width of memory and both ports
DATA_WIDTH, 32, data width; byte-enable width = DATA_WIDTH/8
MEM_LATENCY, 1, BRAM read latency in cycles, legal 1..4
LOCK_MAX, 16, maximum cycles a port may hold a lock, legal 2..255

Ports:
sysclk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
p0_req  in  1  port 0 access request
p0_we  in  1  1 = write, 0 = read
p0_be  in  DATA_WIDTH/8  byte write enables (writes only)
p0_addr  in  ADDR_WIDTH  access address
p0_wdata  in  DATA_WIDTH  write data
p0_lock  in  1  keep ownership after this access
p0_gnt  out  1  access accepted this cycle (combinational)
p0_rvalid  out  1  read data valid for port 0
p0_rdata  out  DATA_WIDTH  read data
p1_*  same nine signals as port 0, for port 1
mem_addr  out  ADDR_WIDTH  BRAM address
mem_wdata  out  DATA_WIDTH  BRAM write data
mem_byte_w_en  out  DATA_WIDTH/8  BRAM byte write enables
mem_r_en  out  1  BRAM read enable
mem_rdata  in  DATA_WIDTH  BRAM read data, valid MEM_LATENCY cycles after address
lock_timeout  out  1  one-cycle pulse: lock forcibly released

Behaviour:
- Clock is sysclk. Reset is synchronous and active-high on rst.
- Accepted access: pX_req=1 and pX_gnt=1 in the same cycle. At most one access is accepted per cycle.
- Memory drive for an accepted access:
  - Winner's addr and wdata drive the memory.
  - mem_byte_w_en = pX_be when we=1, else 0.
  - mem_r_en = ~we.
- With no accepted access: mem_addr=0, mem_wdata=0, mem_byte_w_en=0, mem_r_en=0.
- States: ARB, LOCK0, LOCK1.
- ARB state:
  - If exactly one port requests, it is granted.
  - If both request, the grant goes to the port other than rr_last.
  - rr_last is updated to the winner on every accepted access.
- Entering lock: an accepted access with pX_lock=1 moves the FSM to LOCKX.
- LOCKX state:
  - Only port X can be granted, whenever it requests.
  - The other port's gnt stays 0 even while X is idle.
- Leaving lock normally: an accepted X access with pX_lock=0 returns the FSM to ARB.
- Lock timeout:
  - lock_cnt clears on entering LOCKX and increments every cycle spent in LOCKX.
  - In a LOCKX cycle with lock_cnt==LOCK_MAX-1, the FSM goes to ARB regardless of X activity. X may still be granted in that cycle.
  - On timeout, rr_last is set to X so the other port wins the next tie.
  - lock_timeout is registered and high for exactly the first ARB cycle after the forced exit.
  - If a normal release and the timeout occur in the same cycle, the FSM returns to ARB but lock_timeout stays 0.
- Read return path:
  - Every accepted read pushes {valid=1, owner=X} into a MEM_LATENCY-deep shift pipeline. Writes push valid=0.
  - pX_rvalid = pipeline tail valid and owner==X.
  - p0_rdata = p1_rdata = mem_rdata. Data is qualified only by rvalid.
  - Back-to-back reads from either port, one per cycle, are fully supported with no bubbles.
- Reset values:
  - FSM = ARB, rr_last = 1 (port 0 wins the first tie), lock_cnt = 0.
  - Pipeline cleared; all rvalid = 0; lock_timeout = 0.
  - While rst=1: both gnt = 0 and all mem enables = 0.
- Reset mid-operation: in-flight reads are discarded and never produce rvalid; any lock is dropped.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined, adds two 16-bit outputs:
  - conflict_cnt: saturating count of cycles where both ports requested and one was denied, including denials caused by a lock.
  - timeout_cnt: saturating count of lock_timeout pulses.
- Both counters clear on rst.
- When undefined, these ports and their counters are absent. Behaviour is otherwise identical.

Test Plan:
- Reset, then p0 read addr 0x010 alone → p0_gnt=1 same cycle, mem_r_en=1, mem_addr=0x010; one cycle later p0_rvalid=1 with p0_rdata=mem_rdata and p1_rvalid=0.
- Both ports request reads every cycle for 4 cycles, no lock → grants p0,p1,p0,p1; rvalid alternates p0,p1,p0,p1 starting one cycle later.
- p1 writes 0xDEADBEEF to 0x020 with be=4'b1111 and lock=1, then reads 0x020 with lock=0; p0 requests throughout → p0_gnt=0 for both cycles; p0 granted the following cycle; p1_rvalid carries 0xDEADBEEF.
- LOCK_MAX=4: p0 requests with lock=1 every cycle while p1 also requests → p0 granted 5 times, then ARB with lock_timeout high for one cycle, p1 granted that cycle.
- MEM_LATENCY=2: p0 read at cycle t, p1 read at t+1 → p0_rvalid at t+2, p1_rvalid at t+3, never both high.
- rst asserted one cycle after a p0 read → no p0_rvalid ever appears; gnt=0 and mem_byte_w_en=0 while rst=1; a tie after reset goes to p0.
